pkt_buf_writer: RTL and testbench

- Ingress stage ahead of the shared packet buffer (dual-port RAM, port A write side).
- Accepts a word stream framed by SOP/EOP and writes words into a circular buffer region.
- Drives the RAM's port A address/data/write-enable.
- On a complete packet, queues a descriptor (base address, length) for the egress scheduler. Incomplete or oversize packets are dropped and their space reclaimed.

---
 rtl/pkt_buf_writer.sv | 205 ++++++++++++++++++++
 tb/tb_pkt_buf_writer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_buf_writer.sv
// pkt_buf_writer: ingress writer for the shared packet buffer.
// Frames an SOP/EOP word stream into a circular RAM region. It drives RAM
// port A with registered writes and queues a (base, length) descriptor for
// each complete packet. Incomplete or oversize packets are dropped and the
// words already written for them are given back to the free pool.
module pkt_buf_writer #(
    parameter  int MEM_SIZE   = 1024,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_PKT    = 64,
    parameter  int DESC_DEPTH = 8,
    localparam int AW         = $clog2(MEM_SIZE),
    localparam int LW         = $clog2(MAX_PKT) + 1,
    localparam int DPW        = $clog2(DESC_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [AW-1:0]         desc_addr,
    output logic [LW-1:0]         desc_len,
    input  logic                  free_valid,
    input  logic [LW-1:0]         free_len,
    output logic [15:0]           drop_count
);

    localparam int FW = AW + 2;  // room for free_words plus a return and a refund
    localparam logic [DPW:0]  FULL_CNT = (DPW+1)'(DESC_DEPTH);
    localparam logic [FW-1:0] MEM_CAP  = FW'(MEM_SIZE);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } desc_t;

    state_t        state, state_n;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pkt_base, pkt_base_n;
    logic [LW-1:0] len, len_n;
    logic [AW:0]   free_words;
    logic [FW-1:0] free_sum;

    logic          accept;
    logic          do_write;
    logic          abort;
    logic          drop_inc;
    logic          push;
    desc_t         push_desc;
    logic [LW-1:0] refund;

    desc_t         fifo_mem [DESC_DEPTH];
    logic [DPW-1:0] rd_ptr, wt_ptr;
    logic [DPW:0]  count;
    logic          fifo_full;
    logic          pop;
    desc_t         head;

    assign fifo_full  = (count == FULL_CNT);
    assign desc_valid = (count != '0);
    assign pop        = desc_valid & desc_ready;
    assign head       = fifo_mem[rd_ptr];
    assign desc_addr  = desc_valid ? head.addr : '0;
    assign desc_len   = desc_valid ? head.len  : '0;

    // New packets may only start when a descriptor slot is free; once a
    // packet is in flight its slot is already reserved.
    assign in_ready = (state == IDLE) ? ~fifo_full : 1'b1;
    assign accept   = in_valid & in_ready;
    assign refund   = abort ? len : '0;

    // Next-state and per-word decisions
    always_comb begin
        state_n        = state;
        pkt_base_n     = pkt_base;
        len_n          = len;
        do_write       = 1'b0;
        abort          = 1'b0;
        drop_inc       = 1'b0;
        push           = 1'b0;
        push_desc      = '0;
        case (state)
            IDLE: begin
                if (accept && in_sop) begin
                    if (free_words != '0) begin
                        do_write   = 1'b1;
                        pkt_base_n = wr_ptr;
                        len_n      = LW'(1);
                        if (in_eop) begin
                            push           = 1'b1;
                            push_desc.addr = wr_ptr;
                            push_desc.len  = LW'(1);
                        end else begin
                            state_n = WRITE;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!in_eop) state_n = DROP;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    if (in_sop || free_words == '0 || len == LEN_MAX) begin
                        abort    = 1'b1;
                        drop_inc = 1'b1;
                        state_n  = in_eop ? IDLE : DROP;
                    end else begin
                        do_write = 1'b1;
                        len_n    = len + LW'(1);
                        if (in_eop) begin
                            push           = 1'b1;
                            push_desc.addr = pkt_base;
                            push_desc.len  = len + LW'(1);
                            state_n        = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && in_eop) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Free-space sum: written word, egress return and abort refund together
    always_comb begin
        free_sum = {1'b0, free_words}
                 + FW'(free_valid ? free_len : '0)
                 + FW'(refund)
                 - FW'(do_write);
    end

    // FSM state, packet tracking, pointer and free-space registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pkt_base   <= '0;
            len        <= '0;
            free_words <= (AW+1)'(MEM_SIZE);
        end else begin
            state    <= state_n;
            pkt_base <= pkt_base_n;
            len      <= len_n;
            if (abort)         wr_ptr <= pkt_base;
            else if (do_write) wr_ptr <= wr_ptr + AW'(1);
            free_words <= (free_sum > MEM_CAP) ? (AW+1)'(MEM_SIZE) : free_sum[AW:0];
        end
    end

    // Registered RAM port A: a write shows up one cycle after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr <= wr_ptr;
                mem_data <= in_data;
            end
        end
    end

    // Saturating count of dropped packets
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           drop_count <= '0;
        else if (drop_inc && drop_count != '1)  drop_count <= drop_count + 16'd1;
    end

    // Descriptor storage; outputs are masked while empty so no reset needed
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wt_ptr] <= push_desc;
    end

    // Descriptor FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wt_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wt_ptr <= wt_ptr + DPW'(1);
            if (pop)  rd_ptr <= rd_ptr + DPW'(1);
            case ({push, pop})
                2'b10:   count <= count + (DPW+1)'(1);
                2'b01:   count <= count - (DPW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Self-checking bench for pkt_buf_writer: directed scenarios plus a random
// packet phase, compared against a packet-level reference model.
module tb_pkt_buf_writer;

    localparam int MEM = 1024;
    localparam int MAXP = 64;
    localparam int DD = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        desc_valid;
    logic        desc_ready = 1'b1;
    logic [9:0]  desc_addr;
    logic [6:0]  desc_len;
    logic        free_valid = 1'b0;
    logic [6:0]  free_len = '0;
    logic [15:0] drop_count;

    pkt_buf_writer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len),
        .free_valid(free_valid), .free_len(free_len),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct { int addr; int len; } d_t;
    typedef struct { int addr; int data; } w_t;

    // Reference model state, packet level
    int  m_ptr, m_free, m_base, m_drops;
    bit  m_inpkt, m_dropping;
    int  m_cur[$];       // words already written for the packet in flight
    d_t  m_desc[$];      // descriptors the consumer should see, in order
    w_t  exp_wr[$];      // RAM writes due on the next cycle
    bit  last_acc;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (m_inpkt || m_dropping) return 1'b1;
        return m_desc.size() < DD;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_free = MEM; m_base = 0; m_drops = 0;
        m_inpkt = 0; m_dropping = 0;
        m_cur.delete(); m_desc.delete(); exp_wr.delete();
        last_acc = 0;
    endtask

    task automatic do_write(input int d);
        w_t w;
        w.addr = m_ptr; w.data = d;
        exp_wr.push_back(w);
        m_cur.push_back(d);
        m_ptr = (m_ptr + 1) % MEM;
    endtask

    // Advance the model by one clock edge using the inputs held at that edge
    task automatic step();
        bit rdy, acc, pop, pushd;
        int wrote, refund, old_free;
        d_t nd;
        if (!reset_n) begin last_acc = 0; return; end
        rdy = model_ready();
        acc = in_valid && rdy;
        pop = (m_desc.size() > 0) && desc_ready;
        wrote = 0; refund = 0; pushd = 0;
        old_free = m_free;
        if (acc) begin
            if (m_dropping) begin
                if (in_eop) m_dropping = 0;
            end else if (m_inpkt) begin
                if (in_sop || old_free == 0 || m_cur.size() == MAXP) begin
                    refund = m_cur.size();
                    m_ptr = m_base;
                    m_cur.delete();
                    m_inpkt = 0;
                    m_dropping = !in_eop;
                    if (m_drops < 16'hFFFF) m_drops++;
                end else begin
                    do_write(in_data);
                    wrote = 1;
                    if (in_eop) begin
                        nd.addr = m_base; nd.len = m_cur.size();
                        pushd = 1; m_inpkt = 0; m_cur.delete();
                    end
                end
            end else if (in_sop) begin
                if (old_free > 0) begin
                    m_base = m_ptr;
                    m_cur.delete();
                    do_write(in_data);
                    wrote = 1;
                    if (in_eop) begin
                        nd.addr = m_base; nd.len = 1;
                        pushd = 1; m_cur.delete();
                    end else m_inpkt = 1;
                end else begin
                    if (m_drops < 16'hFFFF) m_drops++;
                    m_dropping = !in_eop;
                end
            end
        end
        m_free = old_free - wrote + (free_valid ? int'(free_len) : 0) + refund;
        if (m_free > MEM) m_free = MEM;
        if (pop) void'(m_desc.pop_front());
        if (pushd) m_desc.push_back(nd);
        last_acc = acc;
    endtask

    // Monitor: compare DUT outputs against the scoreboard away from the edge
    always @(negedge clk) begin
        w_t w;
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", int'(mem_addr), w.addr);
                chk("wr_data", int'(mem_data), w.data);
            end
        end else if (exp_wr.size() != 0) begin
            chk("missing_write", 0, 1);
            exp_wr.delete();
        end
        chk("in_ready", int'(in_ready), int'(model_ready()));
        chk("desc_valid", int'(desc_valid), int'(m_desc.size() != 0));
        if (desc_valid && m_desc.size() != 0) begin
            chk("desc_addr", int'(desc_addr), m_desc[0].addr);
            chk("desc_len", int'(desc_len), m_desc[0].len);
        end
        chk("drop_count", int'(drop_count), m_drops);
    end

    task automatic tick();
        @(posedge clk);
        step();
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) tick();
    endtask

    task automatic side_rand();
        desc_ready = ($urandom_range(0, 3) != 0);
        free_valid = ($urandom_range(0, 5) == 0);
        free_len   = 7'($urandom_range(1, 64));
    endtask

    task automatic send_word(input int d, input bit s, input bit e, input bit rnd);
        int n = 0;
        in_valid = 1; in_data = 16'(d); in_sop = s; in_eop = e;
        do begin
            if (rnd) side_rand();
            tick();
            n++;
        end while (!last_acc && n < 300);
        if (!last_acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
        if (!rnd) free_valid = 0;
    endtask

    task automatic send_pkt(input int base_data, input int n);
        for (int i = 0; i < n; i++) send_word(base_data + i, i == 0, i == n - 1, 0);
    endtask

    task automatic free_ret(input int n);
        free_valid = 1; free_len = 7'(n);
        tick();
        free_valid = 0;
    endtask

    task automatic do_reset();
        in_valid = 0; free_valid = 0;
        reset_n = 0;
        model_reset();
        #1;
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data", int'(mem_data), 0);
        chk("rst_desc_valid", int'(desc_valid), 0);
        chk("rst_desc_addr", int'(desc_addr), 0);
        chk("rst_desc_len", int'(desc_len), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        repeat (3) tick();
        reset_n = 1;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        reset_n = 1;
        tick();

        // Single packet from reset, then next base
        desc_ready = 0;
        send_pkt(16'hA0, 4);
        idle(2);
        chk("single_desc_addr", int'(desc_addr), 0);
        chk("single_desc_len", int'(desc_len), 4);
        desc_ready = 1;
        idle(2);
        desc_ready = 0;
        send_pkt(16'hB0, 2);
        idle(2);
        chk("next_base", int'(desc_addr), 4);
        desc_ready = 1;
        idle(2);

        // Reset in the middle of a packet
        send_word(16'hC0, 1, 0, 0);
        send_word(16'hC1, 0, 0, 0);
        send_word(16'hC2, 0, 0, 0);
        do_reset();
        desc_ready = 0;
        send_pkt(16'hD0, 3);
        idle(2);
        chk("post_reset_base", int'(desc_addr), 0);
        chk("post_reset_len", int'(desc_len), 3);
        desc_ready = 1;
        idle(2);

        // Wrap around the end of the buffer
        do_reset();
        for (int p = 0; p < 16; p++) begin
            send_pkt(p * 64, (p == 15) ? 62 : 64);
            free_ret(64);
        end
        idle(4);
        desc_ready = 0;
        send_pkt(16'hE0, 4);
        idle(2);
        chk("wrap_desc_addr", int'(desc_addr), 1022);
        chk("wrap_desc_len", int'(desc_len), 4);
        desc_ready = 1;
        idle(2);

        // Buffer full: packet dropped, then space returned and accepted
        do_reset();
        for (int p = 0; p < 16; p++) send_pkt(16'h1000 + p * 64, 64);
        idle(4);
        send_pkt(16'hF0, 3);
        idle(2);
        chk("full_drop_count", int'(drop_count), 1);
        chk("full_no_desc", int'(desc_valid), 0);
        free_ret(4);
        desc_ready = 0;
        send_pkt(16'hF8, 4);
        idle(2);
        chk("refill_desc_addr", int'(desc_addr), 0);
        chk("refill_desc_len", int'(desc_len), 4);
        desc_ready = 1;
        idle(2);

        // Oversize packet aborts at word 65 and space is reclaimed
        do_reset();
        send_pkt(16'h2000, 65);
        idle(2);
        chk("oversize_drop", int'(drop_count), 1);
        chk("oversize_no_desc", int'(desc_valid), 0);
        desc_ready = 0;
        send_pkt(16'h3000, 2);
        idle(2);
        chk("oversize_next_base", int'(desc_addr), 0);
        desc_ready = 1;
        idle(2);

        // Descriptor backpressure and SOP mid-packet
        do_reset();
        desc_ready = 0;
        for (int i = 0; i < 8; i++) send_word(16'h400 + i, 1, 1, 0);
        in_valid = 1; in_data = 16'h408; in_sop = 1; in_eop = 1;
        repeat (3) tick();
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_desc_valid", int'(desc_valid), 1);
        desc_ready = 1;
        tick();
        desc_ready = 0;
        chk("bp_ready_after_pop", int'(in_ready), 1);
        send_word(16'h408, 1, 1, 0);
        idle(2);
        desc_ready = 1;
        idle(10);
        send_word(16'h500, 1, 0, 0);
        send_word(16'h501, 0, 0, 0);
        send_word(16'h502, 1, 0, 0);
        send_word(16'h503, 0, 1, 0);
        idle(2);
        chk("sop_abort_drop", int'(drop_count), 1);
        desc_ready = 0;
        send_pkt(16'h600, 2);
        idle(2);
        chk("sop_abort_next_base", int'(desc_addr), 9);
        desc_ready = 1;
        idle(2);

        // Random packets with random backpressure and free returns
        do_reset();
        for (int k = 0; k < 150; k++) begin
            int n;
            n = $urandom_range(1, 70);
            for (int i = 0; i < n; i++) begin
                bit s;
                s = (i == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    side_rand();
                    idle(1);
                end
                send_word($urandom_range(0, 16'hFFFF), s, i == n - 1, 1);
            end
        end
        desc_ready = 1; free_valid = 0;
        idle(20);
        chk("final_fifo_drained", int'(desc_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
